// File: rtl/soft_rst_req_pkg.sv
// Shared definitions for the soft reset request block: register map, FSM codes, default unlock keys.
package soft_rst_req_pkg;

    localparam logic [1:0] SRR_ADDR_STAT   = 2'd0;
    localparam logic [1:0] SRR_ADDR_RELOAD = 2'd1;
    localparam logic [1:0] SRR_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] SRR_ADDR_CTRL   = 2'd3;

    localparam logic [1:0] SRR_IDLE   = 2'd0;
    localparam logic [1:0] SRR_UNLOCK = 2'd1;
    localparam logic [1:0] SRR_FIRE   = 2'd2;

    localparam logic [15:0] SRR_KEY1_DEFAULT = 16'hA5C3;
    localparam logic [15:0] SRR_KEY2_DEFAULT = 16'h5C3A;

    // Field order matches status bits [3:1] and the write-1-to-clear mask on the control address.
    typedef struct packed {
        logic fire;
        logic tmo;
        logic seq;
    } srr_err_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/soft_rst_wdt.sv
// Loadable 16-bit down-counter with kick and expiry pulse; present only when LEDCTRL_SOFT_WDT_EN is defined.
`ifdef LEDCTRL_SOFT_WDT_EN
module soft_rst_wdt (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        kick,
    input  logic [15:0] load_val,
    output logic        on,
    output logic [15:0] reload,
    output logic [15:0] count,
    output logic        expire
);

    // A host write in the expiry cycle (kick or reload) rescues the system.
    assign expire = on && (count == 16'd0) && !load && !kick;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            on     <= 1'b0;
            reload <= 16'd0;
            count  <= 16'd0;
        end else if (load) begin
            reload <= load_val;
            count  <= load_val;
            on     <= (load_val != 16'd0);
        end else if (kick) begin
            count <= reload;
        end else if (expire) begin
            on <= 1'b0;
        end else if (on && count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

endmodule
`endif

// File: rtl/soft_rst_req.sv
// Soft reset request: a keyed two-word unlock raises reset_reg toward the system reset generator.
// Define LEDCTRL_SOFT_WDT_EN to add a host-kicked watchdog that fires the same request.
module soft_rst_req
    import soft_rst_req_pkg::*;
#(
    parameter logic [15:0] KEY1       = SRR_KEY1_DEFAULT,
    parameter logic [15:0] KEY2       = SRR_KEY2_DEFAULT,
    parameter int          UNLOCK_TMO = 64,
    parameter int          FIRE_MAX   = 32
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        reset_reg,
    output logic        busy
);

    localparam logic [7:0] TMO_LAST  = 8'(UNLOCK_TMO - 1);
    localparam logic [7:0] FIRE_LAST = 8'(FIRE_MAX - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [7:0]  tmo_cnt;
    logic [7:0]  fire_cnt;
    srr_err_t    err;
    srr_err_t    err_set;
    srr_err_t    err_clr;
    logic        wr_ok;
    logic        key_wr;
    logic        wdt_on;
    logic        wdt_expire;
    logic [15:0] wdt_reload;
    logic [15:0] wdt_count;

    // Once fired, the block is waiting to be reset by its own request, so every write is locked out.
    assign wr_ok   = wr_en && (state != SRR_FIRE);
    assign key_wr  = wr_ok && (wr_addr == SRR_ADDR_STAT);
    assign err_clr = (wr_ok && wr_addr == SRR_ADDR_CTRL) ? srr_err_t'(wr_data[3:1]) : '0;
    assign busy    = (state != SRR_IDLE);

`ifdef LEDCTRL_SOFT_WDT_EN
    soft_rst_wdt u_wdt (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .load     (wr_ok && wr_addr == SRR_ADDR_RELOAD),
        .kick     (wr_ok && wr_addr == SRR_ADDR_COUNT),
        .load_val (wr_data),
        .on       (wdt_on),
        .reload   (wdt_reload),
        .count    (wdt_count),
        .expire   (wdt_expire)
    );
`else
    assign wdt_on     = 1'b0;
    assign wdt_reload = 16'd0;
    assign wdt_count  = 16'd0;
    assign wdt_expire = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        err_set   = '0;
        case (state)
            SRR_IDLE: begin
                if (key_wr) begin
                    if (wr_data == KEY1) state_nxt = SRR_UNLOCK;
                    else                 err_set.seq = 1'b1;
                end
            end
            SRR_UNLOCK: begin
                if (key_wr) begin
                    if (wr_data == KEY2) begin
                        state_nxt = SRR_FIRE;
                    end else begin
                        state_nxt   = SRR_IDLE;
                        err_set.seq = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt   = SRR_IDLE;
                    err_set.tmo = 1'b1;
                end
            end
            SRR_FIRE: begin
                if (fire_cnt == FIRE_LAST) begin
                    state_nxt    = SRR_IDLE;
                    err_set.fire = 1'b1;
                end
            end
            default: state_nxt = SRR_IDLE;
        endcase
        // Expiry outranks the sequence; a timeout that never took effect is not flagged.
        if (wdt_expire) begin
            state_nxt    = SRR_FIRE;
            err_set.tmo  = 1'b0;
            err_set.fire = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SRR_IDLE;
            tmo_cnt   <= 8'd0;
            fire_cnt  <= 8'd0;
            reset_reg <= 1'b0;
            err       <= '0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= (state == SRR_UNLOCK) ? sat_inc8(tmo_cnt) : 8'd0;
            fire_cnt  <= (state == SRR_FIRE && !wdt_expire) ? sat_inc8(fire_cnt) : 8'd0;
            reset_reg <= (state_nxt == SRR_FIRE);
            err       <= err_set | (err & ~err_clr);
        end
    end

    always_comb begin
        rd_data = 16'd0;
        case (rd_addr)
            SRR_ADDR_STAT:   rd_data = {11'd0, wdt_on, err.fire, err.tmo, err.seq, busy};
            SRR_ADDR_RELOAD: rd_data = wdt_reload;
            SRR_ADDR_COUNT:  rd_data = wdt_count;
            default:         rd_data = {8'd0, state, 5'd0, reset_reg};
        endcase
    end

endmodule

// File: tb/tb_soft_rst_req.sv
// Bench for soft_rst_req: timestamp-based reference model checked every cycle, plus directed vectors.
module tb_soft_rst_req;

    localparam logic [15:0] KEY1       = 16'hA5C3;
    localparam logic [15:0] KEY2       = 16'h5C3A;
    localparam int          UNLOCK_TMO = 64;
    localparam int          FIRE_MAX   = 32;

    logic        sysclk  = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [15:0] wr_data = 16'd0;
    logic [1:0]  rd_addr = 2'd0;
    logic [15:0] rd_data;
    logic        reset_reg;
    logic        busy;

    int checks = 0;
    int errors = 0;

    soft_rst_req dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .reset_reg (reset_reg),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    // Model: phase 0/1/2 = idle/unlock/fire, with entry timestamps instead of counters.
    int          n_edge     = 0;
    int          m_phase    = 0;
    int          t_key1     = 0;
    int          t_fire     = 0;
    logic        e_seq      = 1'b0;
    logic        e_tmo      = 1'b0;
    logic        e_fire     = 1'b0;
    logic        w_on       = 1'b0;
    logic [15:0] w_reload   = 16'd0;
    logic [15:0] w_idle_cnt = 16'd0;
    int          w_deadline = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {15'd0, act}, {15'd0, exp});
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] a);
        logic [15:0] cnt;
        cnt = w_on ? 16'(w_deadline - 1 - n_edge) : w_idle_cnt;
        case (a)
            2'd0:    return {11'd0, w_on, e_fire, e_tmo, e_seq, m_phase != 0};
            2'd1:    return w_reload;
            2'd2:    return cnt;
            default: return {8'd0, 2'(m_phase), 5'd0, m_phase == 2};
        endcase
    endfunction

    initial begin : model
        logic ok, key, clr, ld, kk, expire, s_seq, s_tmo, s_fire;
        forever begin
            @(posedge sysclk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; e_seq = 0; e_tmo = 0; e_fire = 0;
                w_on = 0; w_reload = 0; w_idle_cnt = 0; w_deadline = 0;
            end else begin
                n_edge++;
                ok     = wr_en && m_phase != 2;
                key    = ok && wr_addr == 2'd0;
                clr    = ok && wr_addr == 2'd3;
                ld     = 1'b0;
                kk     = 1'b0;
                expire = 1'b0;
`ifdef LEDCTRL_SOFT_WDT_EN
                ld     = ok && wr_addr == 2'd1;
                kk     = ok && wr_addr == 2'd2;
                expire = w_on && n_edge == w_deadline && !ld && !kk;
`endif
                s_seq = 0; s_tmo = 0; s_fire = 0;
                if (m_phase == 0) begin
                    if (key) begin
                        if (wr_data == KEY1) begin m_phase = 1; t_key1 = n_edge; end
                        else s_seq = 1;
                    end
                end else if (m_phase == 1) begin
                    if (key) begin
                        if (wr_data == KEY2) begin m_phase = 2; t_fire = n_edge; end
                        else begin m_phase = 0; s_seq = 1; end
                    end else if (n_edge - t_key1 >= UNLOCK_TMO) begin
                        m_phase = 0; s_tmo = !expire;
                    end
                end else if (n_edge - t_fire >= FIRE_MAX) begin
                    m_phase = 0; s_fire = !expire;
                end
                if (expire) begin m_phase = 2; t_fire = n_edge; end
                e_seq  = s_seq  | (e_seq  & !(clr & wr_data[1]));
                e_tmo  = s_tmo  | (e_tmo  & !(clr & wr_data[2]));
                e_fire = s_fire | (e_fire & !(clr & wr_data[3]));
                if (ld) begin
                    w_reload = wr_data; w_on = (wr_data != 0);
                    w_deadline = n_edge + int'(wr_data) + 1; w_idle_cnt = wr_data;
                end else if (kk) begin
                    if (w_on) w_deadline = n_edge + int'(w_reload) + 1;
                    else      w_idle_cnt = w_reload;
                end else if (expire) begin
                    w_on = 0; w_idle_cnt = 0;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge sysclk);
            check1("reset_reg", reset_reg, m_phase == 2);
            check1("busy", busy, m_phase != 0);
            for (int a = 0; a < 4; a++) begin
                rd_addr = 2'(a);
                #1;
                check($sformatf("rd_data addr %0d", a), rd_data, m_read(2'(a)));
            end
        end
    end

    // Stimulus changes 2 time units after each rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check1("reset_reg async clear", reset_reg, 1'b0);
        check1("busy async clear", busy, 1'b0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int   hi;
        logic seen;
        cyc(3);
        rst_n = 1'b1;
        check1("reset_reg after reset", reset_reg, 1'b0);
        check("model stat after reset", m_read(2'd0), 16'h0000);

        // KEY1, two idle cycles, KEY2: request one cycle after KEY2.
        wr(2'd0, KEY1);
        check1("busy in unlock", busy, 1'b1);
        check("model ctrl in unlock", m_read(2'd3), 16'h0040);
        cyc(2);
        wr(2'd0, KEY2);
        check1("reset_reg after key2", reset_reg, 1'b1);
        check("model ctrl in fire", m_read(2'd3), 16'h0081);
        cyc(3);
        pulse_reset();

        // Wrong second word, then write-1-to-clear.
        wr(2'd0, KEY1);
        wr(2'd0, 16'h1234);
        check1("reset_reg after bad key2", reset_reg, 1'b0);
        check("model stat err_seq", m_read(2'd0), 16'h0002);
        wr(2'd3, 16'h0002);
        check("model stat cleared", m_read(2'd0), 16'h0000);

        // Unlock timeout after 64 cycles; late KEY2 only flags a sequence error.
        wr(2'd0, KEY1);
        cyc(63);
        check1("busy at last unlock cycle", busy, 1'b1);
        cyc(1);
        check1("busy after timeout", busy, 1'b0);
        check("model stat err_tmo", m_read(2'd0), 16'h0004);
        wr(2'd0, KEY2);
        check("model stat late key2", m_read(2'd0), 16'h0006);
        check1("reset_reg late key2", reset_reg, 1'b0);
        wr(2'd3, 16'h000E);

        // Clear arriving in the cycle err_tmo sets: set wins.
        wr(2'd0, KEY1);
        cyc(63);
        wr(2'd3, 16'h0004);
        check("model set beats clear", m_read(2'd0), 16'h0004);
        wr(2'd3, 16'h0004);

        // KEY2 on the timeout terminal cycle wins; hold rst_n high to see the give-up.
        wr(2'd0, KEY1);
        cyc(63);
        wr(2'd0, KEY2);
        check1("key2 beats timeout", reset_reg, 1'b1);
        hi = 1;
        for (int i = 0; i < 40 && reset_reg; i++) begin
            cyc(1);
            if (reset_reg) hi++;
        end
        check("fire hold cycles", 16'(hi), 16'd32);
        check("model stat err_fire", m_read(2'd0), 16'h0008);
        check1("busy after give-up", busy, 1'b0);

        // Writes in FIRE are ignored, including flag clears.
        wr(2'd0, KEY1);
        wr(2'd0, KEY2);
        wr(2'd3, 16'h000E);
        check("model stat clear ignored in fire", m_read(2'd0), 16'h0009);
        pulse_reset();

        // Writes to other addresses mid-sequence do not break it.
        wr(2'd0, KEY1);
        wr(2'd1, 16'h0007);
        wr(2'd0, KEY2);
        check1("fire survives addr1 write", reset_reg, 1'b1);
        pulse_reset();

`ifdef LEDCTRL_SOFT_WDT_EN
        wr(2'd1, 16'd10);
        cyc(10);
        check1("wdt not yet fired", reset_reg, 1'b0);
        cyc(1);
        check1("wdt fired", reset_reg, 1'b1);
        check("model stat wdt fired", m_read(2'd0), 16'h0001);
        pulse_reset();

        wr(2'd1, 16'd10);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(4);
            wr(2'd2, 16'h0000);
            if (reset_reg) seen = 1'b1;
        end
        check1("kicked wdt never fires", seen, 1'b0);

        wr(2'd1, 16'd3);
        cyc(3);
        wr(2'd2, 16'h0000);
        check1("kick beats expiry", reset_reg, 1'b0);
        check("model count after late kick", m_read(2'd2), 16'd3);
        wr(2'd1, 16'd0);
        check("model stat wdt off", m_read(2'd0), 16'h0000);
`else
        wr(2'd1, 16'h0055);
        wr(2'd2, 16'h0000);
        check("model reload ignored", m_read(2'd1), 16'h0000);
        check("model count ignored", m_read(2'd2), 16'h0000);
        cyc(20);
        check1("no watchdog fire", reset_reg, 1'b0);
`endif

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
